// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes, sequencer FSM states and, with MORSE_ASCII_EN, the ITU decode table.
package morse_pkg;
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_GAP  = 2'b11;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DISCARD} state_t;

`ifdef MORSE_ASCII_EN
    // Key is {length, elements}; element i is bit i, 1 = dash.
    function automatic logic [7:0] morse_ascii(input logic [2:0] len, input logic [4:0] bits);
        case ({len, bits})
            {3'd2, 5'b00010}: return 8'h41;
            {3'd4, 5'b00001}: return 8'h42;
            {3'd4, 5'b00101}: return 8'h43;
            {3'd3, 5'b00001}: return 8'h44;
            {3'd1, 5'b00000}: return 8'h45;
            {3'd4, 5'b00100}: return 8'h46;
            {3'd3, 5'b00011}: return 8'h47;
            {3'd4, 5'b00000}: return 8'h48;
            {3'd2, 5'b00000}: return 8'h49;
            {3'd4, 5'b01110}: return 8'h4A;
            {3'd3, 5'b00101}: return 8'h4B;
            {3'd4, 5'b00010}: return 8'h4C;
            {3'd2, 5'b00011}: return 8'h4D;
            {3'd2, 5'b00001}: return 8'h4E;
            {3'd3, 5'b00111}: return 8'h4F;
            {3'd4, 5'b00110}: return 8'h50;
            {3'd4, 5'b01011}: return 8'h51;
            {3'd3, 5'b00010}: return 8'h52;
            {3'd3, 5'b00000}: return 8'h53;
            {3'd1, 5'b00001}: return 8'h54;
            {3'd3, 5'b00100}: return 8'h55;
            {3'd4, 5'b01000}: return 8'h56;
            {3'd3, 5'b00110}: return 8'h57;
            {3'd4, 5'b01001}: return 8'h58;
            {3'd4, 5'b01101}: return 8'h59;
            {3'd4, 5'b00011}: return 8'h5A;
            {3'd5, 5'b11111}: return 8'h30;
            {3'd5, 5'b11110}: return 8'h31;
            {3'd5, 5'b11100}: return 8'h32;
            {3'd5, 5'b11000}: return 8'h33;
            {3'd5, 5'b10000}: return 8'h34;
            {3'd5, 5'b00000}: return 8'h35;
            {3'd5, 5'b00001}: return 8'h36;
            {3'd5, 5'b00011}: return 8'h37;
            {3'd5, 5'b00111}: return 8'h38;
            {3'd5, 5'b01111}: return 8'h39;
            default:          return 8'h3F;
        endcase
    endfunction
`endif
endpackage

// File: rtl/morse_char_fifo.sv
// morse_char_fifo: synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module morse_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    logic pop, wen;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign valid = wr != rd;
    assign full = wr == {~rd[AW], rd[AW-1:0]};
    assign pop = valid && ready;
    assign wen = push && (!full || pop);
    assign rdata = valid ? mem[rd[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (wen) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (wen) mem[wr[AW-1:0]] <= wdata;
endmodule

// File: rtl/morse_char_sequencer.sv
// morse_char_sequencer: paces the symbol detector and assembles dot/dash symbols into queued characters.
// Defining MORSE_ASCII_EN adds the ascii_o decode of the head entry.
module morse_char_sequencer
    import morse_pkg::*;
#(
    parameter int CLK_DIV       = 50000,
    parameter int MAX_ELEM      = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          sym_i,
    output logic                sample_tick_o,
    output logic                char_valid_o,
    input  logic                char_ready_i,
    output logic [2:0]          char_len_o,
    output logic [MAX_ELEM-1:0] char_bits_o,
    output logic                long_err_o,
    output logic                overflow_o
`ifdef MORSE_ASCII_EN
    ,
    output logic [7:0]          ascii_o
`endif
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [2:0] MAX_LEN = 3'(MAX_ELEM);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_TICKS);

    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [2:0] len, len_d;
    logic [MAX_ELEM-1:0] bits, bits_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [MAX_ELEM+2:0] head;
    logic tick, is_el, is_dash, push, full;

    assign tick = enable && cnt == DIV_END;
    assign sample_tick_o = tick;
    assign is_el = sym_i == SYM_DOT || sym_i == SYM_DASH;
    assign is_dash = sym_i == SYM_DASH;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= (!enable || tick) ? '0 : cnt + 1'b1;

    always_comb begin
        state_d = state;
        len_d = len;
        bits_d = bits;
        tmo_d = tmo;
        push = 1'b0;
        case (state)
            IDLE: if (tick && is_el) begin
                state_d = COLLECT;
                len_d = 3'd1;
                bits_d = MAX_ELEM'(is_dash);
                tmo_d = '0;
            end
            COLLECT: if (tick) begin
                if (is_el && len < MAX_LEN) begin
                    len_d = len + 3'd1;
                    bits_d = bits | (MAX_ELEM'(is_dash) << len);
                    tmo_d = '0;
                end else if (is_el) begin
                    state_d = DISCARD;
                    tmo_d = '0;
                end else if (sym_i == SYM_GAP) begin
                    state_d = EMIT;
                end else begin
                    tmo_d = tmo + 1'b1;
                    if (tmo_d == TMO) state_d = EMIT;
                end
            end
            EMIT: begin
                push = 1'b1;
                state_d = IDLE;
            end
            DISCARD: if (tick) begin
                if (sym_i == SYM_GAP) begin
                    state_d = IDLE;
                end else if (sym_i == SYM_NONE) begin
                    tmo_d = tmo + 1'b1;
                    if (tmo_d == TMO) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping enable abandons whatever character is in flight.
        if (!enable) begin
            state_d = IDLE;
            push = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            len <= '0;
            bits <= '0;
            tmo <= '0;
            long_err_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_d;
            len <= len_d;
            bits <= bits_d;
            tmo <= tmo_d;
            long_err_o <= state_d == DISCARD && state != DISCARD;
            if (push && full && !(char_valid_o && char_ready_i)) overflow_o <= 1'b1;
        end
    end

    morse_char_fifo #(.WIDTH(MAX_ELEM + 3), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({len, bits}),
        .ready (char_ready_i),
        .valid (char_valid_o),
        .rdata (head),
        .full  (full)
    );

    assign {char_len_o, char_bits_o} = head;

`ifdef MORSE_ASCII_EN
    assign ascii_o = char_valid_o ? morse_ascii(char_len_o, 5'(char_bits_o)) : 8'h00;
`endif
endmodule

// File: tb/tb_morse_char_sequencer.sv
// tb_morse_char_sequencer: directed table, hand-written corner sequences and random symbols vs a queue-based model.
module tb_morse_char_sequencer;
    import morse_pkg::*;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b0, char_ready_i = 1'b0;
    logic [1:0] sym_i = SYM_NONE;
    logic sample_tick_o, char_valid_o, long_err_o, overflow_o;
    logic [2:0] char_len_o;
    logic [4:0] char_bits_o;
`ifdef MORSE_ASCII_EN
    logic [7:0] ascii_o;
`endif

    int nvec = 0, nerr = 0;

    morse_char_sequencer #(.CLK_DIV(4), .MAX_ELEM(5), .FIFO_DEPTH(4), .TIMEOUT_TICKS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sym_i         (sym_i),
        .sample_tick_o (sample_tick_o),
        .char_valid_o  (char_valid_o),
        .char_ready_i  (char_ready_i),
        .char_len_o    (char_len_o),
        .char_bits_o   (char_bits_o),
        .long_err_o    (long_err_o),
        .overflow_o    (overflow_o)
`ifdef MORSE_ASCII_EN
        ,
        .ascii_o       (ascii_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a character is a queue of dash flags; emitted characters queue up as {len, bits}.
    logic [7:0] exp_q[$];
    bit m_el[$];
    bit m_disc = 0, ovf_exp = 0, mt;
    int m_idle = 0, pc = 0, long_exp = 0, long_seen = 0, pops = 0;

    function automatic void m_emit();
        logic [4:0] b = '0;
        foreach (m_el[i]) b[i] = m_el[i];
        if (exp_q.size() < 4) exp_q.push_back({3'(m_el.size()), b});
        else ovf_exp = 1;
        m_el.delete();
    endfunction

    function automatic void m_sym(input logic [1:0] s);
        bit el = s == SYM_DOT || s == SYM_DASH;
        if (m_disc) begin
            if (s == SYM_GAP) m_disc = 0;
            else if (s == SYM_NONE) begin
                m_idle = m_idle + 1;
                if (m_idle == 16) m_disc = 0;
            end
        end else if (m_el.size() == 0) begin
            if (el) begin
                m_el.push_back(s == SYM_DASH);
                m_idle = 0;
            end
        end else if (el) begin
            m_idle = 0;
            if (m_el.size() == 5) begin
                m_disc = 1;
                m_el.delete();
                long_exp++;
            end else m_el.push_back(s == SYM_DASH);
        end else if (s == SYM_GAP) m_emit();
        else begin
            m_idle = m_idle + 1;
            if (m_idle == 16) m_emit();
        end
    endfunction

`ifdef MORSE_ASCII_EN
    string mtab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
                        "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--..", "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                        "--...", "---..", "----."};
    string mchr = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    function automatic logic [7:0] ref_ascii(input logic [2:0] len, input logic [4:0] bits);
        string pat = "", ch;
        for (int i = 0; i < int'(len); i++) begin
            ch = bits[i] ? "-" : ".";
            pat = {pat, ch};
        end
        foreach (mtab[i]) if (mtab[i] == pat) return mchr[i];
        return 8'h3F;
    endfunction
`endif

    // Monitor: own tick model, feeds the reference model and scoreboards every pop.
    always @(negedge clk) begin
        if (!rst) begin
            pc = 0;
            m_el.delete();
            m_disc = 0;
            exp_q.delete();
            ovf_exp = 0;
        end else begin
            if (!enable) begin
                pc = 0;
                m_el.delete();
                m_disc = 0;
            end else pc = pc + 1;
            mt = enable && (pc % 4 == 0);
            chk("tick", 32'(sample_tick_o), 32'(mt));
            if (mt) m_sym(sym_i);
            if (long_err_o) long_seen++;
            if (char_valid_o && char_ready_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL pop_unexpected: got len=%0d bits=%b with nothing expected", char_len_o, char_bits_o);
                end else begin
                    chk("pop_entry", {24'b0, char_len_o, char_bits_o}, {24'b0, exp_q[0]});
`ifdef MORSE_ASCII_EN
                    chk("pop_ascii", 32'(ascii_o), 32'(ref_ascii(exp_q[0][7:5], exp_q[0][4:0])));
`endif
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [1:0] s);
        int w = 0;
        @(posedge clk); #1;
        while (!sample_tick_o && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!sample_tick_o) chk("tick_wait", 32'(sample_tick_o), 32'd1);
        sym_i = s;
        @(posedge clk); #1;
        sym_i = SYM_NONE;
    endtask

    task automatic send_str(input string p);
        for (int i = 0; i < p.len(); i++) send(p[i] == "-" ? SYM_DASH : SYM_DOT);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string pat;
        bit to;
        logic [2:0] len;
        logic [4:0] bits;
        bit lng;
        logic [7:0] asc;
    } vec_t;

    vec_t tbl[9];
    string bp[5] = '{".", "-", "..", "--", "-."};

    initial begin
        int n, last, bad, ls, p0;
        logic [1:0] s;
        tbl[0] = '{".-",     1'b0, 3'd2, 5'b00010, 1'b0, 8'h41};
        tbl[1] = '{"-",      1'b1, 3'd1, 5'b00001, 1'b0, 8'h54};
        tbl[2] = '{"......", 1'b0, 3'd0, 5'b00000, 1'b1, 8'h00};
        tbl[3] = '{"-----",  1'b0, 3'd5, 5'b11111, 1'b0, 8'h30};
        tbl[4] = '{"-.-.",   1'b1, 3'd4, 5'b00101, 1'b0, 8'h43};
        tbl[5] = '{".....",  1'b0, 3'd5, 5'b00000, 1'b0, 8'h35};
        tbl[6] = '{".--.-",  1'b0, 3'd5, 5'b10110, 1'b0, 8'h3F};
        tbl[7] = '{"---",    1'b0, 3'd3, 5'b00111, 1'b0, 8'h4F};
        tbl[8] = '{"-.-.--", 1'b1, 3'd0, 5'b00000, 1'b1, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(char_valid_o), 32'd0);
        chk("rst_head", {24'b0, char_len_o, char_bits_o}, 32'd0);
        chk("rst_flags", {29'b0, sample_tick_o, long_err_o, overflow_o}, 32'd0);
        rst = 1'b1;

        // Prescaler: 40 enabled clocks give 10 ticks four clocks apart, none while disabled.
        enable = 1'b1;
        n = 0; last = -1; bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (sample_tick_o) begin
                if (last >= 0 && c - last != 4) bad++;
                if (last < 0) chk("first_tick_at", 32'(c), 32'd4);
                last = c;
                n++;
            end
        end
        chk("tick_count", 32'(n), 32'd10);
        chk("tick_spacing", 32'(bad), 32'd0);
        @(posedge clk); #1;
        enable = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_tick_o) n++;
        end
        chk("tick_disabled", 32'(n), 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;

        foreach (tbl[i]) begin
            ls = long_seen;
            send_str(tbl[i].pat);
            if (tbl[i].to) repeat (16) send(SYM_NONE);
            else send(SYM_GAP);
            settle();
            if (tbl[i].lng) begin
                chk($sformatf("v%0d_long", i), 32'(long_seen - ls), 32'd1);
                chk($sformatf("v%0d_valid", i), 32'(char_valid_o), 32'd0);
            end else begin
                chk($sformatf("v%0d_valid", i), 32'(char_valid_o), 32'd1);
                chk($sformatf("v%0d_len", i), 32'(char_len_o), 32'(tbl[i].len));
                chk($sformatf("v%0d_bits", i), 32'(char_bits_o), 32'(tbl[i].bits));
`ifdef MORSE_ASCII_EN
                chk($sformatf("v%0d_ascii", i), 32'(ascii_o), 32'(tbl[i].asc));
`endif
                char_ready_i = 1'b1;
                @(posedge clk); #1;
                char_ready_i = 1'b0;
                chk($sformatf("v%0d_popped", i), 32'(char_valid_o), 32'd0);
`ifdef MORSE_ASCII_EN
                chk($sformatf("v%0d_ascii_idle", i), 32'(ascii_o), 32'd0);
`endif
            end
        end

        // Enable dropped mid-character: the partial character is lost.
        send_str(".-");
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b1;
        send(SYM_GAP);
        settle();
        chk("en_drop_valid", 32'(char_valid_o), 32'd0);

        // Backpressure: five characters into four entries.
        foreach (bp[i]) begin
            send_str(bp[i]);
            send(SYM_GAP);
        end
        settle();
        chk("bp_overflow", 32'(overflow_o), 32'd1);
        chk("bp_overflow_model", 32'(overflow_o), 32'(ovf_exp));
        chk("bp_valid", 32'(char_valid_o), 32'd1);
        chk("bp_head", {24'b0, char_len_o, char_bits_o}, {24'b0, 3'd1, 5'b00000});
        p0 = pops;
        char_ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        char_ready_i = 1'b0;
        chk("bp_pops", 32'(pops - p0), 32'd4);
        chk("bp_empty", 32'(char_valid_o), 32'd0);
        chk("bp_sticky", 32'(overflow_o), 32'd1);

        // Reset with a queued entry and a half-built character.
        send_str(".");
        send(SYM_GAP);
        send_str(".-");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(char_valid_o), 32'd0);
        chk("mid_rst_head", {24'b0, char_len_o, char_bits_o}, 32'd0);
        chk("mid_rst_flags", {29'b0, sample_tick_o, long_err_o, overflow_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ls = long_seen;
        send(SYM_GAP);
        settle();
        chk("post_rst_gap", 32'(char_valid_o), 32'd0);
        chk("post_rst_long", 32'(long_seen - ls), 32'd0);

        // Random symbol stream with the consumer always ready.
        char_ready_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 99));
            s = n < 40 ? SYM_NONE : n < 65 ? SYM_DOT : n < 90 ? SYM_DASH : SYM_GAP;
            if (n >= 97) repeat (16) send(SYM_NONE);
            else send(s);
        end
        send(SYM_GAP);
        settle();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_valid", 32'(char_valid_o), 32'd0);
        chk("rand_long", 32'(long_seen), 32'(long_exp));
        chk("rand_overflow", 32'(overflow_o), 32'(ovf_exp));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end
endmodule
